// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes for both control widths, and datapath mux selects.
package uc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU3_ADD = 3'b000;
  localparam logic [2:0] ALU3_SUB = 3'b001;
  localparam logic [2:0] ALU3_AND = 3'b010;
  localparam logic [2:0] ALU3_OR  = 3'b011;
  localparam logic [2:0] ALU3_SLT = 3'b101;

  localparam logic [3:0] ALU4_XOR  = 4'b0100;
  localparam logic [3:0] ALU4_SLTU = 4'b0110;
  localparam logic [3:0] ALU4_SLL  = 4'b0111;
  localparam logic [3:0] ALU4_SRL  = 4'b1000;
  localparam logic [3:0] ALU4_SRA  = 4'b1001;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/uc_branch_cond.sv
// Branch-taken evaluation for the six RV32I conditional branches from the ALU
// compare flags; the reserved funct3 codes 010/011 never branch.
module uc_branch_cond (
  input  logic [2:0] f3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/uc_multicycle.sv
// Multicycle RV32I control unit: Moore sequencing FSM with mem_ready wait states.
// Define UC_TRAP_EN to park illegal opcodes in TRAP with a sticky illegal flag.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter bit HAS_WAIT   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            f3,
  input  logic                  f7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  pcWrite,
  output logic                  adrSrc,
  output logic                  memWrite,
  output logic                  irWrite,
  output logic [1:0]            resSrc,
  output logic [1:0]            aluSrcA,
  output logic [1:0]            aluSrcB,
  output logic [1:0]            immSrc,
  output logic [ALU_CTRL_W-1:0] ALUcontrol,
  output logic                  regWrite,
  output logic [3:0]            state,
  output logic                  illegal
);

  localparam bit EXT_OPS = (ALU_CTRL_W >= 4);

  localparam logic [ALU_CTRL_W-1:0] C_ADD  = ALU_CTRL_W'(ALU3_ADD);
  localparam logic [ALU_CTRL_W-1:0] C_SUB  = ALU_CTRL_W'(ALU3_SUB);
  localparam logic [ALU_CTRL_W-1:0] C_AND  = ALU_CTRL_W'(ALU3_AND);
  localparam logic [ALU_CTRL_W-1:0] C_OR   = ALU_CTRL_W'(ALU3_OR);
  localparam logic [ALU_CTRL_W-1:0] C_SLT  = ALU_CTRL_W'(ALU3_SLT);
  localparam logic [ALU_CTRL_W-1:0] C_XOR  = ALU_CTRL_W'(ALU4_XOR);
  localparam logic [ALU_CTRL_W-1:0] C_SLTU = ALU_CTRL_W'(ALU4_SLTU);
  localparam logic [ALU_CTRL_W-1:0] C_SLL  = ALU_CTRL_W'(ALU4_SLL);
  localparam logic [ALU_CTRL_W-1:0] C_SRL  = ALU_CTRL_W'(ALU4_SRL);
  localparam logic [ALU_CTRL_W-1:0] C_SRA  = ALU_CTRL_W'(ALU4_SRA);

  state_t                r_state;
  state_t                w_next;
  logic                  w_ready;
  logic                  w_taken;
  logic [ALU_CTRL_W-1:0] w_alu_fn;

  assign w_ready = HAS_WAIT ? mem_ready : 1'b1;
  assign state   = r_state;

  uc_branch_cond u_branch_cond (
    .f3    (f3),
    .zero  (zero),
    .lt    (lt),
    .ltu   (ltu),
    .taken (w_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXEC_R;
          OP_ITYPE:          w_next = S_EXEC_I;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
`ifdef UC_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC_R,
      S_EXEC_I:   w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

`ifdef UC_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_next == S_TRAP)   r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  // Shift/xor/sltu only exist in the wide ALU; the narrow one falls back to add.
  always_comb begin
    w_alu_fn = C_ADD;
    case (f3)
      3'b000:  w_alu_fn = (op[5] && f7) ? C_SUB : C_ADD;
      3'b010:  w_alu_fn = C_SLT;
      3'b110:  w_alu_fn = C_OR;
      3'b111:  w_alu_fn = C_AND;
      3'b100:  w_alu_fn = EXT_OPS ? C_XOR : C_ADD;
      3'b011:  w_alu_fn = EXT_OPS ? C_SLTU : C_ADD;
      3'b001:  w_alu_fn = EXT_OPS ? C_SLL : C_ADD;
      3'b101:  w_alu_fn = EXT_OPS ? (f7 ? C_SRA : C_SRL) : C_ADD;
      default: w_alu_fn = C_ADD;
    endcase
  end

  always_comb begin
    pcWrite    = 1'b0;
    adrSrc     = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regWrite   = 1'b0;
    resSrc     = RES_ALUOUT;
    aluSrcA    = SRCA_PC;
    aluSrcB    = SRCB_RD2;
    ALUcontrol = C_ADD;
    immSrc     = imm_sel(op);
    case (r_state)
      S_FETCH: begin
        aluSrcB = SRCB_FOUR;
        resSrc  = RES_ALURES;
        irWrite = w_ready;
        pcWrite = w_ready;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB: begin
        resSrc   = RES_DATA;
        regWrite = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      S_EXEC_R: begin
        aluSrcA    = SRCA_RD1;
        ALUcontrol = w_alu_fn;
      end
      S_EXEC_I: begin
        aluSrcA    = SRCA_RD1;
        aluSrcB    = SRCB_IMM;
        ALUcontrol = w_alu_fn;
      end
      S_ALUWB:    regWrite = 1'b1;
      S_BRANCH: begin
        aluSrcA    = SRCA_RD1;
        ALUcontrol = C_SUB;
        pcWrite    = w_taken;
      end
      S_JAL: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_FOUR;
        pcWrite = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pcWrite    = 1'b0;
      adrSrc     = 1'b0;
      memWrite   = 1'b0;
      irWrite    = 1'b0;
      regWrite   = 1'b0;
      resSrc     = 2'b00;
      aluSrcA    = 2'b00;
      aluSrcB    = 2'b00;
      immSrc     = 2'b00;
      ALUcontrol = '0;
    end
  end

endmodule

// File: doc/uc_multicycle.md
Name: uc_multicycle

Overview:
Multicycle RV32I control unit, the successor to the single-cycle control decoder. A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, and a mem_ready handshake supports a shared wait-state memory. Branch evaluation covers all six RV32I conditional branches. The ALU-control width is parametrised. The block sits between the instruction register/flags and the multicycle datapath.

Parameters:
ALU_CTRL_W, 3, ALU control width; 3 gives add/sub/and/or/slt, 4 adds xor/sltu/sll/srl/sra.
HAS_WAIT, 1, 1 honours mem_ready; 0 treats memory as always ready (mem_ready ignored).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  instruction opcode
f3  in  3  funct3
f7  in  1  funct7 bit 5
zero  in  1  ALU result == 0
lt  in  1  signed srcA < srcB
ltu  in  1  unsigned srcA < srcB
mem_ready  in  1  memory access completes this cycle
pcWrite  out  1  PC register enable
adrSrc  out  1  memory address select: 0 PC, 1 result
memWrite  out  1  data memory write strobe
irWrite  out  1  IR/oldPC capture enable
resSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
aluSrcA  out  2  00 PC, 01 oldPC, 10 RD1
aluSrcB  out  2  00 RD2, 01 ImmExt, 10 const 4
immSrc  out  2  00 I, 01 S, 10 B, 11 J
ALUcontrol  out  ALU_CTRL_W  ALU operation
regWrite  out  1  register file write enable
state  out  4  current FSM state, for debug
illegal  out  1  illegal opcode flag (see Optional Feature)

Behaviour:
- Reset: rst_n low immediately forces state FETCH. While rst_n is low, all outputs are 0: all enables, all mux selects, ALUcontrol and illegal.
- Outputs are combinational from state plus inputs; only state (and illegal) are registered.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXEC_R 6, EXEC_I 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11.
- FETCH: adrSrc 0, aluSrcA 00, aluSrcB 10, aluOp add, resSrc 10. irWrite and pcWrite are asserted only when ready; ready = mem_ready, or 1 when HAS_WAIT=0. Advances to DECODE when ready, else holds.
- DECODE: aluSrcA 01, aluSrcB 01, add (computes branch target). Next state by op:
  - 0000011 → MEMADR; 0100011 → MEMADR
  - 0110011 → EXEC_R; 0010011 → EXEC_I
  - 1100011 → BRANCH; 1101111 → JAL
  - any other op → illegal path
- MEMADR: aluSrcA 10, aluSrcB 01, add. → MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adrSrc 1, resSrc 00. Holds until ready, then → MEMWB.
- MEMWB: resSrc 01, regWrite 1 → FETCH.
- MEMWRITE: adrSrc 1, resSrc 00, memWrite held high until ready → FETCH.
- EXEC_R: aluSrcA 10, aluSrcB 00, funct decode. EXEC_I: aluSrcA 10, aluSrcB 01, funct decode. Both → ALUWB.
- ALUWB: resSrc 00, regWrite 1 → FETCH.
- BRANCH: aluSrcA 10, aluSrcB 00, sub, resSrc 00. pcWrite = taken. Next state → FETCH.
  - f3 000 taken=zero; 001 taken=!zero
  - f3 100 taken=lt; 101 taken=!lt
  - f3 110 taken=ltu; 111 taken=!ltu
  - f3 010/011: not taken
- JAL: aluSrcA 01, aluSrcB 10, add, resSrc 00, pcWrite 1 → ALUWB (writes PC+4 to rd).
- immSrc from op in every state: 0100011 S, 1100011 B, 1101111 J, else I.
- Funct decode:
  - f3 000: sub if op[5]&f7, else add
  - f3 010: slt; 110: or; 111: and
  - f3 100 xor, 011 sltu, 001 sll, 101 srl/sra by f7: ALU_CTRL_W=4 only. With ALU_CTRL_W=3 these decode to add.
- ALU encodings, 3-bit: add 000, sub 001, and 010, or 011, slt 101.
- ALU encodings, 4-bit: the 3-bit codes zero-extended, plus xor 0100, sltu 0110, sll 0111, srl 1000, sra 1001.
- Outside EXEC/BRANCH states, ALUcontrol = add.
- Unused mux fields are driven 0 in every state; no X outputs.

Optional Feature:
UC_TRAP_EN
- Defined: an illegal opcode in DECODE → TRAP. TRAP drives all enables 0 and holds until reset; illegal is registered 1 and sticky until rst_n.
- Undefined: an illegal opcode in DECODE → FETCH. The instruction executes as a NOP (PC already advanced in FETCH), and illegal is tied 0.

Decomposition:
- Package uc_pkg: state enum; opcode constants; ALU code constants for both widths; resSrc/aluSrcA/aluSrcB/immSrc encodings.
- One sub-module, uc_branch_cond: combinational taken from f3/zero/lt/ltu.
- FSM and funct decode stay in the top module.

Test Plan:
- lw, HAS_WAIT=1, mem_ready low 2 cycles in FETCH and in MEMREAD → states 0,0,0,1,2,3,3,3,4,0. irWrite/pcWrite high only in the ready cycle of FETCH; regWrite=1, resSrc=01 in MEMWB.
- sw with mem_ready=1 → 0,1,2,5,0. memWrite=1, adrSrc=1 only in state 5; immSrc=01.
- bge (f3=101): lt=1 → pcWrite 0 in BRANCH. lt=0 → pcWrite 1, ALUcontrol=001.
- R-type sra (f3=101, f7=1): ALU_CTRL_W=4 → ALUcontrol 1001 in EXEC_R. ALU_CTRL_W=3 → 000. Then ALUWB regWrite=1.
- jal → 0,1,10,8,0. pcWrite=1 in JAL, aluSrcA=01, aluSrcB=10, immSrc=11.
- op=1111111: with UC_TRAP_EN → state 11, illegal=1 until rst_n low; async reset mid-TRAP → state 0, illegal 0, all outputs 0 during reset. Without the macro → back to FETCH.
